// File: rtl/program_select_ctrl.sv
// Debounces four raw push buttons and turns the first accepted press into
// a fixed-length program code on program_selector, framed by start/busy.
module program_select_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        btn_u,
    input  logic        btn_d,
    output logic        fib_act,
    output logic        sort_act,
    output logic        load_act,
    output logic        save_act,
    output logic [31:0] program_selector,
    output logic        start,
    output logic        busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RELEASE
    } state_e;

    logic [3:0] raw;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] filt;
    logic [3:0] filt_prev_q;
    logic [3:0] rise;
    logic [2:0] new_code;

    state_e        state_q;
    logic [HW-1:0] hold_q;
    logic [31:0]   sel_q;
    logic          start_q;
    logic          busy_q;

    // Bit order: 0=fib(l), 1=sort(r), 2=load(u), 3=save(d)
    assign raw = {btn_d, btn_u, btn_r, btn_l};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_db
        logic [CW-1:0] cnt_q;
        logic          lvl_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync2_q[b] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                cnt_q <= '0;
                lvl_q <= ~lvl_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end

        assign filt[b] = lvl_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_prev_q <= '0;
        end else begin
            filt_prev_q <= filt;
        end
    end

    assign rise = filt & ~filt_prev_q;

    // Lower-priority simultaneous presses are simply dropped
    always_comb begin
        new_code = 3'd0;
        priority case (1'b1)
            rise[0]: new_code = 3'd1;
            rise[1]: new_code = 3'd2;
            rise[2]: new_code = 3'd3;
            rise[3]: new_code = 3'd4;
            default: new_code = 3'd0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            sel_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (|rise) begin
                        state_q <= S_HOLD;
                        hold_q  <= '0;
                        sel_q   <= {29'd0, new_code};
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q <= S_RELEASE;
                        sel_q   <= '0;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                S_RELEASE: begin
                    if (filt == 4'd0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    sel_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fib_act          = filt[0];
    assign sort_act         = filt[1];
    assign load_act         = filt[2];
    assign save_act         = filt[3];
    assign program_selector = sel_q;
    assign start            = start_q;
    assign busy             = busy_q;

endmodule
